// File: rtl/mpt_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : mpt_mem_responder_if
// Brief    : req/gnt/rvalid read bus plus flush and backdoor load port.
// Revision : 1.0 - initial release
// ============================================================================
interface mpt_mem_responder_if #(
    parameter int DEPTH = 512
);
    logic                     req_i;
    logic [63:0]              addr_i;
    logic                     gnt_o;
    logic                     rvalid_o;
    logic [63:0]              rdata_o;
    logic                     err_o;
    logic                     flush_i;
    logic                     bd_we_i;
    logic [$clog2(DEPTH)-1:0] bd_idx_i;
    logic [63:0]              bd_wdata_i;

    modport master (
        output req_i, addr_i, flush_i, bd_we_i, bd_idx_i, bd_wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, addr_i, flush_i, bd_we_i, bd_idx_i, bd_wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/mpt_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mpt_mem_responder
// Brief    : Memory-side responder serving 64-bit MPT entries with fixed
//            grant and read latencies, access-fault flagging and flush.
// Revision : 1.0 - initial release
// ============================================================================
module mpt_mem_responder #(
    parameter int          DEPTH          = 512,
    parameter logic [63:0] BASE_ADDR      = 64'h0,
    parameter int          GNT_LATENCY    = 1,
    parameter int          RVALID_LATENCY = 2
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    mpt_mem_responder_if.slave bus
);
    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_CNT_W = (GNT_LATENCY < 2) ? 1 : $clog2(GNT_LATENCY + 1);
    localparam logic [c_CNT_W-1:0] c_GNT_CNT = c_CNT_W'(GNT_LATENCY);

    localparam logic [0:0] G_IDLE = 1'b0;
    localparam logic [0:0] G_WAIT = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_gnt;

    logic [63:0]        r_mem [DEPTH];
    logic [63:0]        w_off;
    logic [63:0]        w_word;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_err;
    logic [63:0]        w_rdata;

    logic               r_vld   [RVALID_LATENCY];
    logic               r_perr  [RVALID_LATENCY];
    logic [63:0]        r_pdata [RVALID_LATENCY];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= G_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The count starts at 1 on the first held cycle, so a grant comes after
    // GNT_LATENCY extra cycles of a continuously held request.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gnt       = 1'b0;
        case (r_state)
            G_IDLE: begin
                if (bus.req_i) begin
                    if (GNT_LATENCY == 0) begin
                        w_gnt = 1'b1;
                    end else begin
                        w_state_nxt = G_WAIT;
                        w_cnt_nxt   = c_CNT_W'(1);
                    end
                end
            end
            G_WAIT: begin
                if (!bus.req_i) begin
                    w_state_nxt = G_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_GNT_CNT) begin
                    w_gnt       = 1'b1;
                    w_state_nxt = G_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = G_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        if (rst_i) begin
            w_gnt = 1'b0;
        end
    end

    assign w_off   = bus.addr_i - BASE_ADDR;
    assign w_word  = {3'b000, w_off[63:3]};
    assign w_idx   = w_off[c_IDX_W+2:3];
    assign w_err   = (bus.addr_i < BASE_ADDR) || (w_off[2:0] != 3'b000) ||
                     (w_word >= 64'(DEPTH));
    assign w_rdata = w_err ? 64'h0 : r_mem[w_idx];

    // Read happens combinationally in the grant cycle, so a same-edge
    // backdoor write is seen only by later grants.
    always_ff @(posedge clk_i) begin
        if (!rst_i && bus.bd_we_i) begin
            r_mem[bus.bd_idx_i] <= bus.bd_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RVALID_LATENCY; i++) begin
                r_vld[i]   <= 1'b0;
                r_perr[i]  <= 1'b0;
                r_pdata[i] <= '0;
            end
        end else begin
            r_vld[0]   <= w_gnt && !bus.flush_i;
            r_perr[0]  <= w_gnt && w_err;
            r_pdata[0] <= w_gnt ? w_rdata : 64'h0;
            for (int i = 1; i < RVALID_LATENCY; i++) begin
                r_vld[i]   <= r_vld[i-1] && !bus.flush_i;
                r_perr[i]  <= r_perr[i-1];
                r_pdata[i] <= r_pdata[i-1];
            end
        end
    end

    assign bus.gnt_o    = w_gnt;
    assign bus.rvalid_o = r_vld[RVALID_LATENCY-1];
    assign bus.err_o    = r_vld[RVALID_LATENCY-1] && r_perr[RVALID_LATENCY-1];
    assign bus.rdata_o  = r_vld[RVALID_LATENCY-1] ? r_pdata[RVALID_LATENCY-1] : 64'h0;
endmodule
`default_nettype wire

// File: tb/tb_mpt_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpt_mem_responder
// Brief    : Self-checking bench for two responder configurations
//            (A: GNT=1 RVL=2 base 0; B: GNT=0 RVL=3 base 0x100).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mpt_mem_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mpt_mem_responder_if #(.DEPTH(16)) ifa ();
    mpt_mem_responder_if #(.DEPTH(16)) ifb ();

    mpt_mem_responder #(.DEPTH(16), .BASE_ADDR(64'h0), .GNT_LATENCY(1), .RVALID_LATENCY(2))
        u_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
    mpt_mem_responder #(.DEPTH(16), .BASE_ADDR(64'h100), .GNT_LATENCY(0), .RVALID_LATENCY(3))
        u_b (.clk_i(clk), .rst_i(rst), .bus(ifb));

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Stimulus for the current cycle, index 0 = DUT A, 1 = DUT B
    logic        dreq [2];
    logic [63:0] daddr [2];
    logic        dflush [2];
    logic        dwe [2];
    logic [3:0]  didx [2];
    logic [63:0] dwd [2];

    // {gnt, rvalid, err, rdata}
    logic [66:0] ex [2];
    logic [66:0] ob [2];

    // Reference model: word contents, held-request count, queue of due responses
    typedef struct packed {
        int          d;
        int          due;
        logic        err;
        logic [63:0] data;
    } ent_t;
    logic [63:0] mm [2][16];
    int          hold [2];
    logic        eg [2];
    ent_t        pq [$];

    function automatic int gl(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    function automatic int rvl(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic logic [63:0] base_of(input int d);
        return (d == 0) ? 64'h0 : 64'h100;
    endfunction

    function automatic logic [64:0] resp(input int d, input logic [63:0] a);
        logic [63:0] off;
        if (a < base_of(d)) return {1'b1, 64'h0};
        off = a - base_of(d);
        if ((off % 8) != 0 || (off / 8) >= 16) return {1'b1, 64'h0};
        return {1'b0, mm[d][int'(off / 8)]};
    endfunction

    function automatic int front(input int d);
        for (int i = 0; i < pq.size(); i++) if (pq[i].d == d) return i;
        return -1;
    endfunction

    function automatic logic [63:0] rand_addr(input int d);
        int r;
        r = int'($urandom_range(0, 9));
        case (r)
            0: return base_of(d) + 64'd4 + 64'(8 * $urandom_range(0, 15));
            1: return base_of(d) + 64'(8 * (16 + $urandom_range(0, 3)));
            2: return base_of(d) - 64'd8;
            default: return base_of(d) + 64'(8 * $urandom_range(0, 15));
        endcase
    endfunction

    task automatic idle_drv();
        for (int d = 0; d < 2; d++) begin
            dreq[d] = 1'b0; daddr[d] = 64'h0; dflush[d] = 1'b0;
            dwe[d] = 1'b0; didx[d] = 4'h0; dwd[d] = 64'h0;
        end
    endtask

    // One cycle: apply stimulus at the falling edge, predict and sample,
    // then advance the model across the rising edge.
    task automatic tick();
        logic [64:0] r;
        int f;
        ifa.req_i = dreq[0]; ifa.addr_i = daddr[0]; ifa.flush_i = dflush[0];
        ifa.bd_we_i = dwe[0]; ifa.bd_idx_i = didx[0]; ifa.bd_wdata_i = dwd[0];
        ifb.req_i = dreq[1]; ifb.addr_i = daddr[1]; ifb.flush_i = dflush[1];
        ifb.bd_we_i = dwe[1]; ifb.bd_idx_i = didx[1]; ifb.bd_wdata_i = dwd[1];
        #1;
        for (int d = 0; d < 2; d++) begin
            eg[d] = !rst && dreq[d] && (hold[d] >= gl(d));
            f = front(d);
            if (f >= 0 && pq[f].due == cyc)
                ex[d] = {eg[d], 1'b1, pq[f].err, pq[f].data};
            else
                ex[d] = {eg[d], 66'h0};
        end
        ob[0] = {ifa.gnt_o, ifa.rvalid_o, ifa.err_o, ifa.rdata_o};
        ob[1] = {ifb.gnt_o, ifb.rvalid_o, ifb.err_o, ifb.rdata_o};
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst || dflush[d]) begin
                for (int i = pq.size() - 1; i >= 0; i--) if (pq[i].d == d) pq.delete(i);
            end else begin
                f = front(d);
                if (f >= 0 && pq[f].due == cyc) pq.delete(f);
                if (eg[d]) begin
                    r = resp(d, daddr[d]);
                    pq.push_back('{d: d, due: cyc + rvl(d), err: r[64], data: r[63:0]});
                end
            end
            if (rst || eg[d] || !dreq[d]) hold[d] = 0;
            else hold[d] = hold[d] + 1;
            if (!rst && dwe[d]) mm[d][didx[d]] = dwd[d];
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_drv();
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ob[d] !== 67'h0) begin
                errors++;
                $display("FAIL reset_outputs dut=%0d got=%h exp=0", d, ob[d]);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            for (int d = 0; d < 2; d++) begin
                dwe[d] = 1'b1; didx[d] = 4'(i); dwd[d] = {$urandom, $urandom};
            end
            tick();
        end
        idle_drv();
        tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ob[d] !== ex[d]) begin
                errors++;
                $display("FAIL reset_idle dut=%0d got=%h exp=%h", d, ob[d], ex[d]);
            end
        end
    endtask

    task automatic test_basic();
        idle_drv();
        dwe[0] = 1'b1; didx[0] = 4'd3; dwd[0] = 64'hA5A5_0000_0000_0003;
        tick();
        for (int k = 0; k < 6; k++) begin
            idle_drv();
            if (k < 2) begin dreq[0] = 1'b1; daddr[0] = 64'h18; end
            tick();
            checks++;
            if (ob[0] !== ex[0]) begin
                errors++;
                $display("FAIL basic_model k=%0d got=%h exp=%h", k, ob[0], ex[0]);
            end
            if (k == 1 || k == 3) begin
                checks++;
                if ((k == 1 && ob[0][66] !== 1'b1) ||
                    (k == 3 && ob[0][65:0] !== {2'b10, 64'hA5A5_0000_0000_0003})) begin
                    errors++;
                    $display("FAIL basic_fixed k=%0d got=%h", k, ob[0]);
                end
            end
        end
    endtask

    task automatic test_err();
        for (int k = 0; k < 7; k++) begin
            idle_drv();
            if (k < 2) begin dreq[0] = 1'b1; daddr[0] = 64'h1C; end
            else if (k < 4) begin dreq[0] = 1'b1; daddr[0] = 64'h80; end
            tick();
            checks++;
            if (ob[0] !== ex[0]) begin
                errors++;
                $display("FAIL err_model k=%0d got=%h exp=%h", k, ob[0], ex[0]);
            end
            if (k == 3 || k == 5) begin
                checks++;
                if (ob[0][65:0] !== {2'b11, 64'h0}) begin
                    errors++;
                    $display("FAIL err_fixed k=%0d got=%h exp=%h", k, ob[0][65:0], {2'b11, 64'h0});
                end
            end
        end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 8; k++) begin
            idle_drv();
            if (k < 4) begin dreq[1] = 1'b1; daddr[1] = 64'h100 + 64'(8 * k); end
            tick();
            checks++;
            if (ob[1] !== ex[1]) begin
                errors++;
                $display("FAIL stream_model k=%0d got=%h exp=%h", k, ob[1], ex[1]);
            end
            checks++;
            if ((k < 4 && ob[1][66] !== 1'b1) ||
                (k >= 3 && k <= 6 && ob[1][65:0] !== {2'b10, mm[1][k-3]})) begin
                errors++;
                $display("FAIL stream_fixed k=%0d got=%h", k, ob[1]);
            end
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 12; k++) begin
            idle_drv();
            if (k < 2) begin dreq[1] = 1'b1; daddr[1] = 64'h100 + 64'(8 * k); end
            if (k == 2) dflush[1] = 1'b1;
            if (k == 7) begin dreq[1] = 1'b1; daddr[1] = 64'h110; end
            tick();
            checks++;
            if (ob[1] !== ex[1]) begin
                errors++;
                $display("FAIL flush_model k=%0d got=%h exp=%h", k, ob[1], ex[1]);
            end
            if ((k >= 2 && k <= 6) || k == 10) begin
                checks++;
                if ((k != 10 && ob[1][65] !== 1'b0) ||
                    (k == 10 && ob[1][65:0] !== {2'b10, mm[1][2]})) begin
                    errors++;
                    $display("FAIL flush_fixed k=%0d got=%h", k, ob[1]);
                end
            end
        end
    endtask

    task automatic test_backdoor();
        logic [63:0] old_v, new_v;
        old_v = mm[0][5];
        new_v = ~old_v ^ 64'h0123_4567_89AB_CDEF;
        for (int k = 0; k < 9; k++) begin
            idle_drv();
            if (k < 2 || k == 4 || k == 5) begin dreq[0] = 1'b1; daddr[0] = 64'h28; end
            if (k == 1) begin dwe[0] = 1'b1; didx[0] = 4'd5; dwd[0] = new_v; end
            tick();
            checks++;
            if (ob[0] !== ex[0]) begin
                errors++;
                $display("FAIL backdoor_model k=%0d got=%h exp=%h", k, ob[0], ex[0]);
            end
            if (k == 3 || k == 7) begin
                checks++;
                if (ob[0][65:0] !== {2'b10, (k == 3) ? old_v : new_v}) begin
                    errors++;
                    $display("FAIL backdoor_fixed k=%0d got=%h", k, ob[0][63:0]);
                end
            end
        end
    endtask

    task automatic test_withdraw_reset();
        logic [63:0] old7;
        old7 = mm[0][7];
        for (int k = 0; k < 12; k++) begin
            idle_drv();
            rst = (k == 4);
            if (k == 0 || k == 2 || k == 3) begin dreq[0] = 1'b1; daddr[0] = 64'h0; end
            if (k == 4) begin dwe[0] = 1'b1; didx[0] = 4'd7; dwd[0] = ~old7; end
            if (k == 7 || k == 8) begin dreq[0] = 1'b1; daddr[0] = 64'h38; end
            tick();
            checks++;
            if (ob[0] !== ex[0]) begin
                errors++;
                $display("FAIL wdrst_model k=%0d got=%h exp=%h", k, ob[0], ex[0]);
            end
            if (k <= 1 || k == 5 || k == 6 || k == 10) begin
                checks++;
                if ((k <= 1 && ob[0][66] !== 1'b0) ||
                    ((k == 5 || k == 6) && ob[0] !== 67'h0) ||
                    (k == 10 && ob[0][65:0] !== {2'b10, old7})) begin
                    errors++;
                    $display("FAIL wdrst_fixed k=%0d got=%h", k, ob[0]);
                end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            idle_drv();
            rst = ($urandom_range(0, 99) == 0);
            for (int d = 0; d < 2; d++) begin
                dreq[d]   = ($urandom_range(0, 3) != 0);
                daddr[d]  = rand_addr(d);
                dflush[d] = ($urandom_range(0, 19) == 0);
                dwe[d]    = ($urandom_range(0, 7) == 0);
                didx[d]   = 4'($urandom_range(0, 15));
                dwd[d]    = {$urandom, $urandom};
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (ob[d] !== ex[d]) begin
                    errors++;
                    $display("FAIL random dut=%0d k=%0d got=%h exp=%h", d, k, ob[d], ex[d]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        hold[0] = 0;
        hold[1] = 0;
        idle_drv();
        @(negedge clk);
        test_reset();
        test_basic();
        test_err();
        test_stream();
        test_flush();
        test_backdoor();
        test_withdraw_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
